// File: rtl/b_to_o_dec.sv
// rtl/b_to_o_dec.sv - registered 3-to-8 one-hot decoder with hold time and guard cycle
// Optional odd-parity check on b enabled by `define B_TO_O_PARITY_EN.
module b_to_o_dec #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] b,
`ifdef B_TO_O_PARITY_EN
  input  logic       b_par,
  output logic       err,
`endif
  output logic [7:0] o,
  output logic       o_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] o_nx;
  logic       o_valid_nx;
  logic       accept;
  logic       par_ok;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

`ifdef B_TO_O_PARITY_EN
  logic err_nx;
  assign par_ok = ^{b, b_par};
  assign err_nx = accept && !par_ok;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    o_nx       = o;
    o_valid_nx = o_valid;
    case (state)
      IDLE: begin
        // A code failing parity is consumed without leaving IDLE
        if (accept && par_ok) begin
          state_nx   = DRIVE;
          cnt_nx     = HOLD_LOAD;
          o_nx       = 8'b1 << b;
          o_valid_nx = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt != 8'd0) begin
          cnt_nx = cnt - 8'd1;
        end else begin
          state_nx   = GAP;
          o_nx       = 8'h00;
          o_valid_nx = 1'b0;
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx   = IDLE;
        o_nx       = 8'h00;
        o_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      o       <= 8'h00;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      o       <= o_nx;
      o_valid <= o_valid_nx;
    end
  end

`ifdef B_TO_O_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_b_to_o_dec.sv
// tb/tb_b_to_o_dec.sv - self-checking bench for b_to_o_dec at HOLD_CYCLES 4 and 1
module tb_b_to_o_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] b;
  logic       b_par;
  logic       in_ready_w [2];
  logic [7:0] o_w        [2];
  logic       o_valid_w  [2];
  logic       busy_w     [2];
`ifdef B_TO_O_PARITY_EN
  logic       err_w      [2];
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: each instance is described by the edge of its last
  // decoded acceptance and the code taken then; everything else is arithmetic.
  int   e = 0;
  int   acc_edge [2] = '{-1000, -1000};
  int   acc_code [2] = '{0, 0};
  logic err_exp  [2] = '{1'b0, 1'b0};
  logic acc_now  [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  b_to_o_dec #(.HOLD_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .b(b),
`ifdef B_TO_O_PARITY_EN
    .b_par(b_par), .err(err_w[0]),
`endif
    .o(o_w[0]), .o_valid(o_valid_w[0]), .busy(busy_w[0])
  );

  b_to_o_dec #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .b(b),
`ifdef B_TO_O_PARITY_EN
    .b_par(b_par), .err(err_w[1]),
`endif
    .o(o_w[1]), .o_valid(o_valid_w[1]), .busy(busy_w[1])
  );

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic model_idle(input int d);
    int age;
    age = e - acc_edge[d];
    return !(age >= 0 && age <= hold_of(d));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int         age;
    logic [7:0] exp_o;
    logic       exp_busy;
    for (int d = 0; d < 2; d++) begin
      age      = e - acc_edge[d];
      exp_o    = (age >= 0 && age < hold_of(d)) ? 8'(1 << acc_code[d]) : 8'h00;
      exp_busy = (age >= 0 && age <= hold_of(d));
      chk($sformatf("o[%0d]", d), o_w[d], exp_o);
      chk($sformatf("o_valid[%0d]", d), {7'd0, o_valid_w[d]}, {7'd0, exp_o != 8'h00});
      chk($sformatf("busy[%0d]", d), {7'd0, busy_w[d]}, {7'd0, exp_busy});
      chk($sformatf("in_ready[%0d]", d), {7'd0, in_ready_w[d]}, {7'd0, !exp_busy && !rst});
      chk($sformatf("onehot0[%0d]", d), {7'd0, $onehot0(o_w[d])}, 8'd1);
`ifdef B_TO_O_PARITY_EN
      chk($sformatf("err[%0d]", d), {7'd0, err_w[d]}, {7'd0, err_exp[d]});
`endif
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check at negedge.
  task automatic step(input logic v, input logic [2:0] code, input logic par, input logic r);
    int   age;
    logic rdy;
    logic par_ok;
    in_valid = v;
    b        = code;
    b_par    = par;
    rst      = r;
`ifdef B_TO_O_PARITY_EN
    par_ok = ^{code, par};
`else
    par_ok = 1'b1;
`endif
    @(posedge clk);
    e++;
    for (int d = 0; d < 2; d++) begin
      age        = e - 1 - acc_edge[d];
      rdy        = !r && !(age >= 0 && age <= hold_of(d));
      err_exp[d] = 1'b0;
      acc_now[d] = 1'b0;
      if (r) begin
        acc_edge[d] = -1000;
      end else if (v && rdy) begin
        if (par_ok) begin
          acc_edge[d] = e;
          acc_code[d] = int'(code);
          acc_now[d]  = 1'b1;
        end else begin
          err_exp[d] = 1'b1;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(model_idle(0) && model_idle(1)) && n < 20) begin
      step(1'b0, 3'd0, 1'b1, 1'b0);
      n++;
    end
    if (n >= 20) chk("wait_idle_timeout", 8'd1, 8'd0);
  endtask

  initial begin
    int   n;
    logic v;
    logic r;
    logic [2:0] c;
    logic p;

    // Reset held two cycles, then code 5
    step(1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    chk("reset_o", o_w[0], 8'h00);
    chk("reset_ready", {7'd0, in_ready_w[0]}, 8'd0);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    chk("code5_o", o_w[0], 8'h20);
    chk("code5_h1_o", o_w[1], 8'h20);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("code5_in_ready", {7'd0, in_ready_w[0]}, 8'd0);
    wait_idle();

    // Sweep all codes with in_valid held high
    for (int k = 0; k < 8; k++) begin
      c = 3'(k);
      n = 0;
      do begin
        step(1'b1, c, ~^c, 1'b0);
        n++;
      end while (!acc_now[0] && n < 20);
      if (n >= 20) chk("sweep_timeout", 8'd1, 8'd0);
      chk("sweep_o", o_w[0], 8'(1 << k));
    end
    wait_idle();

    // Code 7 presented while busy must be ignored until IDLE
    step(1'b1, 3'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd7, 1'b0, 1'b0);
      chk("busy_hold_o", o_w[0], 8'h04);
    end
    n = 0;
    while (!acc_now[0] && n < 20) begin
      step(1'b1, 3'd7, 1'b0, 1'b0);
      n++;
    end
    chk("late_accept_o", o_w[0], 8'h80);
    wait_idle();

    // Reset on the second DRIVE cycle
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b1);
    chk("abort_o", o_w[0], 8'h00);
    chk("abort_busy", {7'd0, busy_w[0]}, 8'd0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("abort_ready", {7'd0, in_ready_w[0]}, 8'd1);

    // Short hold instance: code 1 for one cycle, gap, ready
    step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("h1_o", o_w[1], 8'h02);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    chk("h1_gap_o", o_w[1], 8'h00);
    chk("h1_gap_busy", {7'd0, busy_w[1]}, 8'd1);
    wait_idle();

`ifdef B_TO_O_PARITY_EN
    // Code 3 carries two ones, so b_par=0 breaks odd parity
    step(1'b1, 3'd3, 1'b0, 1'b0);
    chk("par_err", {7'd0, err_w[0]}, 8'd1);
    chk("par_err_o", o_w[0], 8'h00);
    step(1'b1, 3'd3, 1'b1, 1'b0);
    chk("par_ok_o", o_w[0], 8'h08);
    chk("par_ok_err", {7'd0, err_w[0]}, 8'd0);
    wait_idle();
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 99) < 3);
      c = 3'($urandom_range(0, 7));
      p = ~^c;
`ifdef B_TO_O_PARITY_EN
      if ($urandom_range(0, 9) == 0) p = ~p;
`endif
      step(v, c, p, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
